store_monitor: RTL and testbench
================================

Name: store_monitor

Overview:
Observes the processor's data-store bus (MemWrite, DataAdr, WriteData) at the processor/data-memory boundary and consumes every store the core issues. Logs each store into a small FIFO drained over a valid/ready port. Detects the terminal store to DONE_ADDR and declares pass or fail from the stored value. Raises timeout if no terminal store arrives within a cycle budget. Used by the simulation bench and the FPGA status/LED path.

Parameters:
XLEN, 64, data/address width of the store bus
DEPTH, 8, FIFO entries (power of two, >= 2)
DONE_ADDR, 64'd100, address whose store ends the test
PASS_VALUE, 64'd25, value at DONE_ADDR meaning pass
TIMEOUT, 1000, cycles in RUN before declaring timeout (>= 1)

Ports:
clk  in  1  rising-edge clock shared with the processor
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
MemWrite  in  1  store strobe from the core, one store per cycle when high
DataAdr  in  XLEN  store address
WriteData  in  XLEN  store data
log_ready  in  1  consumer accepts the head FIFO entry
log_valid  out  1  FIFO non-empty
log_addr  out  XLEN  address of the head entry
log_data  out  XLEN  data of the head entry
store_count  out  32  stores accepted while in RUN, saturating
overflow  out  1  sticky: a store was dropped because the FIFO was full
done  out  1  state is PASS, FAIL or TIMEOUT
pass  out  1  state is PASS
fail  out  1  state is FAIL or TIMEOUT
timeout  out  1  state is TIMEOUT

Behaviour:
- Reset (reset=0, asynchronous): state=RUN, FIFO empty, cycle counter=0, store_count=0. All outputs 0, including log_addr and log_data.
- FSM states RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are terminal and sticky until reset.
- In RUN, on a cycle with MemWrite=1 (a store cycle):
  - Push {DataAdr, WriteData} into the FIFO if not full, or if full with a pop in the same cycle.
  - Otherwise drop the store and set overflow.
  - Increment store_count, saturating at 32'hFFFFFFFF. It counts dropped stores too.
  - If DataAdr==DONE_ADDR: next state is PASS when WriteData==PASS_VALUE, else FAIL. The terminal store is itself logged.
- Cycle counter increments every cycle in RUN. If the counter equals TIMEOUT-1 and no terminal store occurs that cycle, next state is TIMEOUT. A terminal store in that same cycle wins over timeout.
- In terminal states: stores are ignored (not logged, not counted), the cycle counter holds, and the FIFO keeps draining.
- FIFO is register-based and first-word-fall-through:
  - A store pushed on edge N is visible on log_valid/log_addr/log_data after edge N (i.e. during cycle N+1). Latency is 1 cycle.
  - Pop occurs when log_valid & log_ready.
  - Read/write pointers wrap modulo DEPTH. Occupancy count is DEPTH+1 states wide.
  - Push and pop in the same cycle leave occupancy unchanged, including when full (no drop) and when holding 1 entry.
  - With log_valid=0, log_ready is ignored. log_addr/log_data hold their last values when empty.
- done, pass, fail and timeout are registered decodes of state. They assert the cycle after the deciding edge.
- Reset asserted mid-run discards all FIFO contents and status immediately.

Decomposition:
- Shared package store_monitor_pkg holds:
  - state encoding constants (RUN=2'd0, PASS=2'd1, FAIL=2'd2, TIMEOUT=2'd3)
  - default DONE_ADDR and PASS_VALUE
- One sub-module, mon_fifo: parameterised DEPTH/width synchronous FIFO with push/pop/full/empty. Same clk and active-low asynchronous reset.
- FSM, counters and decode stay in store_monitor.

Test Plan:
- Reset then three stores (0x10/0xA, 0x18/0xB, 0x20/0xC) with log_ready=1 -> three entries emerge in order, each 1 cycle after its store; store_count=3; done=0.
- Store 100/25 -> pass=1, done=1 the next cycle; entry (100,25) logged; a later store to 0x30 is neither logged nor counted.
- Store 100/7 -> fail=1, pass=0, timeout=0.
- log_ready=0, then 9 consecutive stores with DEPTH=8 -> 8 entries kept, the 9th dropped, overflow=1, store_count=9; then a simultaneous push and pop at full -> no drop, occupancy stays 8.
- TIMEOUT=20 with no terminal store -> timeout=1 and fail=1 after 20 RUN cycles. Separately, store 100/25 on cycle 19 -> pass wins.
- Drop reset to 0 mid-run with 4 entries queued -> log_valid=0, store_count=0, overflow=0, state RUN immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/store_monitor_pkg.sv
// store_monitor_pkg
// Shared definitions for the store monitor: FSM state encoding and the
// default terminal-store address / pass value.
package store_monitor_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  localparam logic [63:0] DEFAULT_DONE_ADDR  = 64'd100;
  localparam logic [63:0] DEFAULT_PASS_VALUE = 64'd25;

endpackage

// File: rtl/mon_fifo.sv
// mon_fifo
// Register-based first-word-fall-through FIFO.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, wdata     write request and data (ignored when full unless popping)
//   pop             read request (ignored when empty)
//   rdata           head entry; holds its last value while empty, 0 after reset
//   full, empty     occupancy flags
// A push on edge N is visible on rdata/!empty during cycle N+1.
module mon_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_nxt;
  logic [CW-1:0]    count;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] head_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);
  assign rd_nxt  = rd_ptr + AW'(do_pop);
  assign rdata   = head_q;

  always_comb begin
    cnt_nxt = count;
    if (do_push && !do_pop) cnt_nxt = count + 1'b1;
    else if (!do_push && do_pop) cnt_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_nxt;
      count  <= cnt_nxt;
      // The head is registered so it can hold while empty. When the new
      // head is the entry being written this edge, take it from wdata.
      if (cnt_nxt != '0) begin
        if (do_push && (wr_ptr == rd_nxt)) head_q <= wdata;
        else head_q <= mem[rd_nxt];
      end
    end
  end

endmodule

// File: rtl/store_monitor.sv
// store_monitor
// Watches the core's data-store bus, logs every store taken in RUN into a
// FIFO, and ends the test on the store to DONE_ADDR (pass/fail by value)
// or after TIMEOUT cycles in RUN.
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   MemWrite, DataAdr, WriteData    store bus from the core
//   log_valid, log_ready            log port handshake
//   log_addr, log_data              head log entry
//   store_count                     stores seen in RUN (saturating, incl. drops)
//   overflow                        sticky: a store was dropped on a full FIFO
//   done, pass, fail, timeout       registered status decodes
//   dbg_state                       current FSM state
// Log handshake: an entry transfers on every rising edge where log_valid
// and log_ready are both high; log_ready is ignored while log_valid is low
// and log_valid never depends on log_ready.
module store_monitor
  import store_monitor_pkg::*;
#(
  parameter int              XLEN       = 64,
  parameter int              DEPTH      = 8,
  parameter logic [XLEN-1:0] DONE_ADDR  = XLEN'(DEFAULT_DONE_ADDR),
  parameter logic [XLEN-1:0] PASS_VALUE = XLEN'(DEFAULT_PASS_VALUE),
  parameter int              TIMEOUT    = 1000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemWrite,
  input  logic [XLEN-1:0] DataAdr,
  input  logic [XLEN-1:0] WriteData,
  input  logic            log_ready,
  output logic            log_valid,
  output logic [XLEN-1:0] log_addr,
  output logic [XLEN-1:0] log_data,
  output logic [31:0]     store_count,
  output logic            overflow,
  output logic            done,
  output logic            pass,
  output logic            fail,
  output logic            timeout,
  output logic [1:0]      dbg_state
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cyc_q;
  logic          store;
  logic          terminal;
  logic          fifo_full;
  logic          fifo_empty;

  // Stores only matter while running; terminal states ignore the bus.
  assign store     = (state_q == ST_RUN) && MemWrite;
  assign terminal  = store && (DataAdr == DONE_ADDR);
  assign log_valid = !fifo_empty;
  assign dbg_state = state_q;

  mon_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (store),
    .pop   (log_ready),
    .wdata ({DataAdr, WriteData}),
    .rdata ({log_addr, log_data}),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A terminal store on the last budget cycle takes priority over timeout.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN) begin
      if (terminal) state_d = (WriteData == PASS_VALUE) ? ST_PASS : ST_FAIL;
      else if (cyc_q == CW'(TIMEOUT - 1)) state_d = ST_TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_RUN;
    else state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q       <= '0;
      store_count <= '0;
      overflow    <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      if ((state_q == ST_RUN) && (cyc_q != CW'(TIMEOUT - 1))) cyc_q <= cyc_q + 1'b1;
      if (store && (store_count != 32'hFFFF_FFFF)) store_count <= store_count + 1'b1;
      // Full with no pop this cycle means the store cannot be kept.
      if (store && fifo_full && !log_ready) overflow <= 1'b1;
      // Decoding the next state makes the flags line up with state_q.
      done    <= (state_d != ST_RUN);
      pass    <= (state_d == ST_PASS);
      fail    <= (state_d == ST_FAIL) || (state_d == ST_TIMEOUT);
      timeout <= (state_d == ST_TIMEOUT);
    end
  end

endmodule

// File: tb/tb_store_monitor.sv
// tb_store_monitor
// Bench for store_monitor: dut_a uses the default cycle budget, dut_t a
// budget of 20 for the timeout cases. Both see the same bus.
module tb_store_monitor;
  import store_monitor_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite = 1'b0;
  logic [63:0] DataAdr = '0;
  logic [63:0] WriteData = '0;
  logic        log_ready = 1'b0;

  logic        a_log_valid, a_overflow, a_done, a_pass, a_fail, a_timeout;
  logic [63:0] a_log_addr, a_log_data;
  logic [31:0] a_store_count;
  logic [1:0]  a_state;
  logic        t_log_valid, t_overflow, t_done, t_pass, t_fail, t_timeout;
  logic [63:0] t_log_addr, t_log_data;
  logic [31:0] t_store_count;
  logic [1:0]  t_state;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  store_monitor #(.TIMEOUT(1000)) dut_a (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .log_ready(log_ready), .log_valid(a_log_valid),
    .log_addr(a_log_addr), .log_data(a_log_data), .store_count(a_store_count),
    .overflow(a_overflow), .done(a_done), .pass(a_pass), .fail(a_fail),
    .timeout(a_timeout), .dbg_state(a_state)
  );

  store_monitor #(.TIMEOUT(20)) dut_t (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .log_ready(log_ready), .log_valid(t_log_valid),
    .log_addr(t_log_addr), .log_data(t_log_data), .store_count(t_store_count),
    .overflow(t_overflow), .done(t_done), .pass(t_pass), .fail(t_fail),
    .timeout(t_timeout), .dbg_state(t_state)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of bus inputs; returns 1 time unit after the edge.
  task automatic apply(input logic we, input logic [63:0] a, input logic [63:0] d,
                       input logic rdy, input bit logged);
    MemWrite  = we;
    DataAdr   = a;
    WriteData = d;
    log_ready = rdy;
    if (logged) exp_q.push_back({a, d});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    MemWrite  = 1'b0;
    DataAdr   = '0;
    WriteData = '0;
    log_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"},   a_log_valid, 0);
    chk({tag, "_addr"},    a_log_addr, 0);
    chk({tag, "_data"},    a_log_data, 0);
    chk({tag, "_count"},   a_store_count, 0);
    chk({tag, "_ovf"},     a_overflow, 0);
    chk({tag, "_done"},    a_done, 0);
    chk({tag, "_pass"},    a_pass, 0);
    chk({tag, "_fail"},    a_fail, 0);
    chk({tag, "_timeout"}, a_timeout, 0);
    chk({tag, "_state"},   a_state, 64'(ST_RUN));
  endtask

  // ---------------- scoreboard ----------------
  // Every transfer on dut_a's log port must match the oldest expected entry.
  initial begin
    logic [127:0] e;
    forever begin
      @(negedge clk);
      if (reset && a_log_valid && log_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL log_extra: got %0h/%0h expected no entry", a_log_addr, a_log_data);
        end else begin
          e = exp_q.pop_front();
          if ({a_log_addr, a_log_data} !== e) begin
            errors++;
            $display("FAIL log_entry: got %0h/%0h expected %0h/%0h",
                     a_log_addr, a_log_data, e[127:64], e[63:0]);
          end
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [63:0] adr;
    logic [63:0] wd;
    logic        rdy;
    bit          logged;
    logic        exp_valid;
    logic [31:0] exp_cnt;
    logic        exp_done;
    logic        exp_pass;
    logic        exp_fail;
  } vec_t;

  vec_t tbl [7];

  initial begin
    tbl[0] = '{1'b1, 64'h10, 64'hA, 1'b1, 1'b1, 1'b1, 32'd1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 64'h18, 64'hB, 1'b1, 1'b1, 1'b1, 32'd2, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 64'h20, 64'hC, 1'b1, 1'b1, 1'b1, 32'd3, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 64'h0,  64'h0, 1'b1, 1'b0, 1'b0, 32'd3, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 64'd100, 64'd25, 1'b1, 1'b1, 1'b1, 32'd4, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 64'h30, 64'h5, 1'b1, 1'b0, 1'b0, 32'd4, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 64'h0,  64'h0, 1'b1, 1'b0, 1'b0, 32'd4, 1'b1, 1'b1, 1'b0};

    reset = 1'b1;
    #2;

    // Reset state
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    do_reset();

    // Ordered logging, pass decision, and stores ignored after done
    for (int i = 0; i < 7; i++) begin
      apply(tbl[i].we, tbl[i].adr, tbl[i].wd, tbl[i].rdy, tbl[i].logged);
      chk($sformatf("vec%0d_valid", i), a_log_valid, tbl[i].exp_valid);
      chk($sformatf("vec%0d_count", i), a_store_count, tbl[i].exp_cnt);
      chk($sformatf("vec%0d_done", i), a_done, tbl[i].exp_done);
      chk($sformatf("vec%0d_pass", i), a_pass, tbl[i].exp_pass);
      chk($sformatf("vec%0d_fail", i), a_fail, tbl[i].exp_fail);
    end
    chk("vec_drained", exp_q.size(), 0);

    // Wrong value at DONE_ADDR
    do_reset();
    apply(1'b1, 64'd100, 64'd7, 1'b1, 1'b1);
    chk("fail_fail", a_fail, 1);
    chk("fail_pass", a_pass, 0);
    chk("fail_timeout", a_timeout, 0);
    chk("fail_done", a_done, 1);
    chk("fail_state", a_state, 64'(ST_FAIL));
    apply(1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
    chk("fail_drained", a_log_valid, 0);

    // Overflow with a stalled consumer, then push+pop while full
    do_reset();
    for (int i = 0; i < 9; i++) begin
      apply(1'b1, 64'h40 + 64'(i * 8), 64'(i), 1'b0, (i < 8));
      if (i == 7) chk("ovf_before", a_overflow, 0);
    end
    chk("ovf_flag", a_overflow, 1);
    chk("ovf_count", a_store_count, 9);
    chk("ovf_head", a_log_addr, 64'h40);
    apply(1'b1, 64'h80, 64'h99, 1'b1, 1'b1);
    chk("ovf_pushpop_count", a_store_count, 10);
    chk("ovf_sticky", a_overflow, 1);
    apply(1'b1, 64'h88, 64'h77, 1'b0, 1'b0);
    chk("ovf_still_full_count", a_store_count, 11);
    repeat (9) apply(1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
    chk("ovf_drained_q", exp_q.size(), 0);
    chk("ovf_drained_valid", a_log_valid, 0);

    // Timeout after 20 RUN cycles
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      apply(1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
      if (k == 19) begin
        chk("to_early_timeout", t_timeout, 0);
        chk("to_early_done", t_done, 0);
      end
    end
    chk("to_timeout", t_timeout, 1);
    chk("to_fail", t_fail, 1);
    chk("to_done", t_done, 1);
    chk("to_pass", t_pass, 0);
    chk("to_state", t_state, 64'(ST_TIMEOUT));
    chk("to_long_budget_done", a_done, 0);

    // Terminal store on the last budget cycle beats timeout
    do_reset();
    repeat (19) apply(1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
    apply(1'b1, 64'd100, 64'd25, 1'b1, 1'b1);
    chk("race_pass", t_pass, 1);
    chk("race_timeout", t_timeout, 0);
    chk("race_fail", t_fail, 0);
    apply(1'b0, 64'h0, 64'h0, 1'b1, 1'b0);

    // Asynchronous reset mid-run with entries queued
    do_reset();
    for (int i = 0; i < 4; i++) apply(1'b1, 64'h200 + 64'(i), 64'(i + 1), 1'b0, 1'b0);
    chk("arst_pre_valid", a_log_valid, 1);
    chk("arst_pre_count", a_store_count, 4);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outputs("arst");
    @(negedge clk);
    reset = 1'b1;
    apply(1'b1, 64'h300, 64'h33, 1'b1, 1'b1);
    chk("arst_after_valid", a_log_valid, 1);
    chk("arst_after_count", a_store_count, 1);
    apply(1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
    chk("arst_after_drained", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
